mem_bus_arbiter: RTL

- Shares the core's single valid/ready memory port between two requesters: instruction fetch (read-only) and the execute stage's load/store unit.
- Sits between those two requesters and the external memory interface.
- Registers a grant and holds it until the transaction completes.
- Provides fixed-priority or round-robin arbitration and a watchdog that terminates hung transactions with an error.

---
 rtl/mem_bus_arbiter_if.sv | 45 ++++
 rtl/mem_bus_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bundles the fetch, load/store and downstream memory signals of the
// memory bus arbiter. The master view belongs to the arbiter; the slave
// view belongs to the requesters and the memory around it.
interface mem_bus_arbiter_if;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;

  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] d_rdata;

  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  logic        bus_error;

  modport master (
    input  i_valid, i_addr,
    output i_ready, i_rdata,
    input  d_valid, d_addr, d_wdata, d_wstrb,
    output d_ready, d_rdata,
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata,
    output bus_error
  );

  modport slave (
    output i_valid, i_addr,
    input  i_ready, i_rdata,
    output d_valid, d_addr, d_wdata, d_wstrb,
    input  d_ready, d_rdata,
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata,
    input  bus_error
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one valid/ready memory port between instruction fetch and the
// load/store unit. A grant is registered and held until the owner's
// transaction completes, aborts, or is terminated by the watchdog.
module mem_bus_arbiter #(
  parameter bit          DATA_PRIORITY = 1'b1,
  parameter int unsigned TIMEOUT       = 1024
) (
  input logic               clk,
  input logic               rstn,
  mem_bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic        GrantI   = 1'b0;
  localparam logic        GrantD   = 1'b1;
  localparam logic        WdEnable = (TIMEOUT != 0);
  localparam logic [15:0] CntLast  = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        lastGrant_q, lastGrant_d;
  logic [15:0] cnt_q, cnt_d;
  logic        timeoutHit;

  // Registered state: FSM, last granted port and watchdog counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      lastGrant_q <= GrantD;
      cnt_q       <= 16'd0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      cnt_q       <= cnt_d;
    end
  end

  // Watchdog fires on the last allowed BUSY cycle unless memory answers in it.
  always_comb begin
    timeoutHit = WdEnable && (state_q != IDLE) && (cnt_q == CntLast) && !bus.mem_ready;
  end

  // Read data passes straight through; a terminated transaction returns zero.
  always_comb begin
    bus.i_rdata = timeoutHit ? 32'd0 : bus.mem_rdata;
    bus.d_rdata = timeoutHit ? 32'd0 : bus.mem_rdata;
  end

  // Next-state logic, grant decision and downstream/handshake outputs.
  always_comb begin
    state_d       = state_q;
    lastGrant_d   = lastGrant_q;
    cnt_d         = cnt_q;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = 32'd0;
    bus.mem_wdata = 32'd0;
    bus.mem_wstrb = 4'b0000;
    bus.i_ready   = 1'b0;
    bus.d_ready   = 1'b0;
    bus.bus_error = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.d_valid &&
            (!bus.i_valid || DATA_PRIORITY || (lastGrant_q == GrantI))) begin
          state_d     = BUSY_D;
          lastGrant_d = GrantD;
          cnt_d       = 16'd0;
        end else if (bus.i_valid) begin
          state_d     = BUSY_I;
          lastGrant_d = GrantI;
          cnt_d       = 16'd0;
        end
      end

      BUSY_I: begin
        bus.mem_valid = bus.i_valid;
        bus.mem_addr  = bus.i_addr;
        if (!bus.i_valid) begin
          state_d = IDLE;
        end else if (bus.mem_ready || timeoutHit) begin
          bus.i_ready   = 1'b1;
          bus.bus_error = timeoutHit;
          state_d       = IDLE;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      BUSY_D: begin
        bus.mem_valid = bus.d_valid;
        bus.mem_addr  = bus.d_addr;
        bus.mem_wdata = bus.d_wdata;
        bus.mem_wstrb = bus.d_wstrb;
        if (!bus.d_valid) begin
          state_d = IDLE;
        end else if (bus.mem_ready || timeoutHit) begin
          bus.d_ready   = 1'b1;
          bus.bus_error = timeoutHit;
          state_d       = IDLE;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
